fp_div_sqrt_scheduler: RTL and testbench

FP_DIV_SQRT_SCHEDULER -- requirements
Module: fp_div_sqrt_scheduler

---
 rtl/fp_div_sqrt_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_fp_div_sqrt_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_sqrt_scheduler.sv
// fp_div_sqrt_scheduler
//   Tracks a pool of NUM_CH iterative divide/sqrt channels. A requester
//   reserves a FREE channel (round-robin search), then starts a divide or a
//   square root on it. The channel counts down its latency and holds the
//   result until released. A selective flush by active-list range, or a full
//   flush, returns a channel to FREE from any state.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   acq_req       request to reserve a channel
//   acq_al_ptr    active-list index of the requester
//   acq_grant     reservation accepted this cycle (combinational)
//   acq_ch        granted channel, 0 when no grant
//   start         per-channel operation start
//   start_is_div  per-channel op select, 1 = divide, 0 = sqrt
//   release_ch    per-channel result consumed ("release" is a reserved word)
//   flush_valid   selective flush this cycle
//   flush_all     flush every channel (qualified by flush_valid)
//   flush_head    flush range head, inclusive
//   flush_tail    flush range tail, exclusive
//   ch_free, ch_reserved, ch_busy, ch_finished  registered state decode
//   any_free      OR of ch_free
module fp_div_sqrt_scheduler #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AL_IDX_W = 6,
  parameter int unsigned DIV_LAT  = 12,
  parameter int unsigned SQRT_LAT = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      acq_req,
  input  logic [AL_IDX_W-1:0]                       acq_al_ptr,
  output logic                                      acq_grant,
  output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] acq_ch,
  input  logic [NUM_CH-1:0]                         start,
  input  logic [NUM_CH-1:0]                         start_is_div,
  input  logic [NUM_CH-1:0]                         release_ch,
  input  logic                                      flush_valid,
  input  logic                                      flush_all,
  input  logic [AL_IDX_W-1:0]                       flush_head,
  input  logic [AL_IDX_W-1:0]                       flush_tail,
  output logic [NUM_CH-1:0]                         ch_free,
  output logic [NUM_CH-1:0]                         ch_reserved,
  output logic [NUM_CH-1:0]                         ch_busy,
  output logic [NUM_CH-1:0]                         ch_finished,
  output logic                                      any_free
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_RESERVED = 2'd1,
    ST_BUSY     = 2'd2,
    ST_WAITING  = 2'd3
  } ch_state_e;

  ch_state_e           state_q [NUM_CH];
  ch_state_e           state_d [NUM_CH];
  logic [AL_IDX_W-1:0] owner_q [NUM_CH];
  logic [AL_IDX_W-1:0] owner_d [NUM_CH];
  logic [CNT_W-1:0]    cnt_q   [NUM_CH];
  logic [CNT_W-1:0]    cnt_d   [NUM_CH];
  logic [CH_W-1:0]     rr_q;
  logic [CH_W-1:0]     rr_d;

  logic [NUM_CH-1:0]   free_vec;
  logic [NUM_CH-1:0]   flush_hit;
  logic                acq_flushed;
  logic                free_found;
  logic                grant;
  logic [CH_W-1:0]     grant_ch;

  // Circular active-list range [head, tail); head == tail is empty.
  function automatic logic in_range(input logic [AL_IDX_W-1:0] head,
                                    input logic [AL_IDX_W-1:0] tail,
                                    input logic [AL_IDX_W-1:0] p);
    if (head < tail)
      return (p >= head) && (p < tail);
    else if (head > tail)
      return (p >= head) || (p < tail);
    else
      return 1'b0;
  endfunction

  always_comb begin
    flush_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      flush_hit[i] = flush_valid & (flush_all | in_range(flush_head, flush_tail, owner_q[i]));
    end
    acq_flushed = flush_valid & (flush_all | in_range(flush_head, flush_tail, acq_al_ptr));
  end

  // Round-robin search done as two linear passes (rr..N-1, then 0..rr-1)
  // so no modulo index is needed.
  always_comb begin
    free_vec   = '0;
    free_found = 1'b0;
    grant_ch   = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      free_vec[j] = (state_q[j] == ST_FREE);
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!free_found && (j >= 32'(rr_q)) && free_vec[j]) begin
        free_found = 1'b1;
        grant_ch   = CH_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!free_found && (j < 32'(rr_q)) && free_vec[j]) begin
        free_found = 1'b1;
        grant_ch   = CH_W'(j);
      end
    end
  end

  // Reset level gates the grant so nothing is offered while held in reset.
  always_comb begin
    grant     = rst & acq_req & free_found & ~acq_flushed;
    acq_grant = grant;
    acq_ch    = grant ? grant_ch : '0;
    rr_d      = rr_q;
    if (grant) begin
      if (grant_ch == CH_W'(NUM_CH - 1))
        rr_d = '0;
      else
        rr_d = grant_ch + CH_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      owner_d[i] = owner_q[i];
      cnt_d[i]   = cnt_q[i];
      if (flush_hit[i] && (state_q[i] != ST_FREE)) begin
        state_d[i] = ST_FREE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          ST_FREE: begin
            if (grant && (grant_ch == CH_W'(i))) begin
              state_d[i] = ST_RESERVED;
              owner_d[i] = acq_al_ptr;
            end
          end
          ST_RESERVED: begin
            if (start[i]) begin
              state_d[i] = ST_BUSY;
              cnt_d[i]   = start_is_div[i] ? CNT_W'(DIV_LAT - 1) : CNT_W'(SQRT_LAT - 1);
            end
          end
          ST_BUSY: begin
            if (cnt_q[i] == '0)
              state_d[i] = ST_WAITING;
            else
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
          ST_WAITING: begin
            if (release_ch[i])
              state_d[i] = ST_FREE;
          end
          default: state_d[i] = ST_FREE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_FREE;
        owner_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        owner_q[i] <= owner_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    ch_free     = '0;
    ch_reserved = '0;
    ch_busy     = '0;
    ch_finished = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_free[i]     = (state_q[i] == ST_FREE);
      ch_reserved[i] = (state_q[i] == ST_RESERVED);
      ch_busy[i]     = (state_q[i] == ST_BUSY);
      ch_finished[i] = (state_q[i] == ST_WAITING);
    end
    any_free = |ch_free;
  end

endmodule

// File: tb/tb_fp_div_sqrt_scheduler.sv
// Testbench for fp_div_sqrt_scheduler: directed vector table, hand-written
// latency/flush/reset sequences, then random traffic against a timestamp
// based reference model.
module tb_fp_div_sqrt_scheduler;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 6;
  localparam int unsigned DL  = 12;
  localparam int unsigned SL  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            acq_req = 1'b0;
  logic [AW-1:0]   acq_al_ptr = '0;
  logic            acq_grant;
  logic [0:0]      acq_ch;
  logic [NCH-1:0]  start = '0;
  logic [NCH-1:0]  start_is_div = '0;
  logic [NCH-1:0]  release_ch = '0;
  logic            flush_valid = 1'b0;
  logic            flush_all = 1'b0;
  logic [AW-1:0]   flush_head = '0;
  logic [AW-1:0]   flush_tail = '0;
  logic [NCH-1:0]  ch_free, ch_reserved, ch_busy, ch_finished;
  logic            any_free;

  int errors = 0;
  int checks = 0;

  fp_div_sqrt_scheduler #(
    .NUM_CH(NCH), .AL_IDX_W(AW), .DIV_LAT(DL), .SQRT_LAT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .acq_req(acq_req), .acq_al_ptr(acq_al_ptr),
    .acq_grant(acq_grant), .acq_ch(acq_ch),
    .start(start), .start_is_div(start_is_div), .release_ch(release_ch),
    .flush_valid(flush_valid), .flush_all(flush_all),
    .flush_head(flush_head), .flush_tail(flush_tail),
    .ch_free(ch_free), .ch_reserved(ch_reserved),
    .ch_busy(ch_busy), .ch_finished(ch_finished), .any_free(any_free)
  );

  always #5 clk = ~clk;

  // Reference model: 0 free, 1 reserved, 2 running. A running channel
  // reports finished once the edge count reaches its completion stamp.
  int     m_st   [NCH];
  int     m_own  [NCH];
  longint m_done [NCH];
  int     m_rr;
  longint ecnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_in_rng(input int h, input int t, input int p);
    return ((p - h + 64) % 64) < ((t - h + 64) % 64);
  endfunction

  function automatic bit m_flushed(input int p);
    return flush_valid && (flush_all || m_in_rng(int'(flush_head), int'(flush_tail), p));
  endfunction

  function automatic bit m_waiting(input int i);
    return (m_st[i] == 2) && (ecnt >= m_done[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = 0; m_own[i] = 0; m_done[i] = 0;
    end
    m_rr = 0;
    ecnt = 0;
  endtask

  task automatic m_grant(output bit g, output int ch);
    g = 0; ch = 0;
    for (int k = 0; k < NCH; k++) begin
      if (m_st[(m_rr + k) % NCH] == 0) begin
        g = 1; ch = (m_rr + k) % NCH;
        break;
      end
    end
    if (!acq_req || m_flushed(int'(acq_al_ptr))) g = 0;
    if (!g) ch = 0;
  endtask

  task automatic m_edge();
    bit g; int ch;
    m_grant(g, ch);
    for (int i = 0; i < NCH; i++) begin
      if (m_st[i] != 0 && m_flushed(m_own[i])) m_st[i] = 0;
      else if (m_st[i] == 0) begin
        if (g && ch == i) begin m_st[i] = 1; m_own[i] = int'(acq_al_ptr); end
      end else if (m_st[i] == 1) begin
        if (start[i]) begin
          m_st[i] = 2;
          m_done[i] = ecnt + 1 + (start_is_div[i] ? DL : SL);
        end
      end else if (m_waiting(i) && release_ch[i]) m_st[i] = 0;
    end
    if (g) m_rr = (ch + 1) % NCH;
    ecnt++;
  endtask

  task automatic check_regs(input string tag);
    logic [NCH-1:0] ef, er, eb, ew;
    for (int i = 0; i < NCH; i++) begin
      ef[i] = (m_st[i] == 0);
      er[i] = (m_st[i] == 1);
      eb[i] = (m_st[i] == 2) && !m_waiting(i);
      ew[i] = m_waiting(i);
    end
    chk({tag, "/ch_free"}, ch_free, ef);
    chk({tag, "/ch_reserved"}, ch_reserved, er);
    chk({tag, "/ch_busy"}, ch_busy, eb);
    chk({tag, "/ch_finished"}, ch_finished, ew);
    chk({tag, "/any_free"}, any_free, |ef);
  endtask

  // Inputs are set at the falling edge before calling; returns at the next
  // falling edge with the model advanced by one rising edge.
  task automatic cycle(input string tag);
    bit g; int ch;
    #1;
    m_grant(g, ch);
    chk({tag, "/acq_grant"}, acq_grant, g);
    chk({tag, "/acq_ch"}, acq_ch, ch);
    @(posedge clk);
    m_edge();
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    acq_req = 0; acq_al_ptr = '0; start = '0; start_is_div = '0; release_ch = '0;
    flush_valid = 0; flush_all = 0; flush_head = '0; flush_tail = '0;
  endtask

  typedef struct {
    bit             req;
    logic [AW-1:0]  ptr;
    bit             fv;
    logic [AW-1:0]  fh;
    logic [AW-1:0]  ft;
    bit             exp_g;
    logic [0:0]     exp_ch;
    logic [NCH-1:0] exp_free;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1, 6'd62, 0, 6'd0,  6'd0,  1, 1'b0, 2'b10};
    tbl[1] = '{1, 6'd3,  0, 6'd0,  6'd0,  1, 1'b1, 2'b00};
    tbl[2] = '{1, 6'd9,  0, 6'd0,  6'd0,  0, 1'b0, 2'b00};
    tbl[3] = '{0, 6'd0,  1, 6'd60, 6'd2,  0, 1'b0, 2'b01};
    tbl[4] = '{1, 6'd10, 1, 6'd10, 6'd10, 1, 1'b0, 2'b00};
    tbl[5] = '{0, 6'd0,  1, 6'd2,  6'd4,  0, 1'b0, 2'b10};
    tbl[6] = '{1, 6'd7,  1, 6'd5,  6'd9,  0, 1'b0, 2'b10};
    tbl[7] = '{1, 6'd7,  0, 6'd0,  6'd0,  1, 1'b1, 2'b00};

    m_reset();
    idle_inputs();
    acq_req = 1;
    #3;
    chk("rst/acq_grant", acq_grant, 0);
    chk("rst/acq_ch", acq_ch, 0);
    chk("rst/ch_free", ch_free, 2'b11);
    chk("rst/ch_busy", ch_busy | ch_reserved | ch_finished, 2'b00);
    chk("rst/any_free", any_free, 1);
    @(negedge clk);
    rst = 1;
    idle_inputs();

    for (int v = 0; v < 8; v++) begin
      idle_inputs();
      acq_req = tbl[v].req; acq_al_ptr = tbl[v].ptr;
      flush_valid = tbl[v].fv; flush_head = tbl[v].fh; flush_tail = tbl[v].ft;
      #1;
      chk($sformatf("tbl%0d/grant", v), acq_grant, tbl[v].exp_g);
      chk($sformatf("tbl%0d/ch", v), acq_ch, tbl[v].exp_ch);
      cycle($sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d/free", v), ch_free, tbl[v].exp_free);
    end

    // ch0 divide and ch1 sqrt start on the same edge; a restart of ch1 and
    // an early release of ch0 while busy must both be ignored.
    idle_inputs();
    start = 2'b11; start_is_div = 2'b01;
    cycle("lat0");
    chk("lat0/busy", ch_busy, 2'b11);
    for (int k = 1; k <= 17; k++) begin
      idle_inputs();
      if (k == 3) begin start = 2'b10; start_is_div = 2'b10; end
      if (k == 5) release_ch = 2'b01;
      cycle($sformatf("lat%0d", k));
      chk($sformatf("lat%0d/div_busy", k), ch_busy[0], k < 12);
      chk($sformatf("lat%0d/div_fin", k), ch_finished[0], k >= 12);
      chk($sformatf("lat%0d/sqrt_fin", k), ch_finished[1], k >= 16);
    end
    idle_inputs();
    release_ch = 2'b01;
    cycle("rel0");
    chk("rel0/free", ch_free, 2'b01);
    idle_inputs();
    release_ch = 2'b10; flush_valid = 1; flush_head = 6'd7; flush_tail = 6'd8;
    cycle("flrel");
    chk("flrel/free", ch_free, 2'b11);

    // Reset while ch0 is busy with four cycles left on its counter.
    idle_inputs();
    acq_req = 1; acq_al_ptr = 6'd20;
    cycle("racq");
    idle_inputs();
    start = 2'b01; start_is_div = 2'b01;
    cycle("rstart");
    for (int k = 0; k < 7; k++) begin
      idle_inputs();
      cycle($sformatf("rrun%0d", k));
    end
    chk("rrun/busy", ch_busy[0], 1);
    #2 rst = 0;
    #1;
    chk("arst/ch_free", ch_free, 2'b11);
    chk("arst/ch_busy", ch_busy, 2'b00);
    chk("arst/any_free", any_free, 1);
    acq_req = 1; acq_al_ptr = 6'd1;
    #1;
    chk("arst/acq_grant", acq_grant, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    m_reset();
    cycle("post_rst_acq");
    chk("post_rst_acq/free", ch_free, 2'b10);
    for (int k = 0; k < 20; k++) begin
      idle_inputs();
      cycle($sformatf("post%0d", k));
      chk($sformatf("post%0d/no_fin", k), ch_finished, 2'b00);
    end

    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      acq_req      = ($urandom_range(0, 1) == 1);
      acq_al_ptr   = AW'($urandom);
      start        = NCH'($urandom_range(0, 3) & $urandom_range(0, 3));
      start_is_div = NCH'($urandom);
      release_ch   = NCH'($urandom);
      flush_valid  = ($urandom_range(0, 7) == 0);
      flush_all    = ($urandom_range(0, 3) == 0);
      flush_head   = AW'($urandom);
      flush_tail   = ($urandom_range(0, 1) == 1) ? AW'(flush_head + AW'($urandom_range(0, 8)))
                                                 : AW'($urandom);
      cycle($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
